// File: rtl/line_clear_ctrl.sv
// -----------------------------------------------------------------------------
// line_clear_ctrl
//
// Purpose:
//   Row-clear engine for a block-stacking playfield stored in an external
//   grid RAM with a one-cycle registered read. A pass scans the rows from the
//   bottom (ROWS-1) to the top (0). When a row has no empty cells, every row
//   above it moves down by one, row 0 is zeroed, and the same row index is
//   scanned again. At the end of the pass, the number of removed rows is
//   reported.
//
// Parameters:
//   COLS  cells per grid row (default 10)
//   ROWS  grid rows, row 0 at the top (default 12); ROWS*COLS must fit 7 bits
//
// Ports:
//   clock          rising-edge clock for all state
//   reset_n        asynchronous active-low reset
//   start          one-cycle request for a pass (ignored unless idle)
//   busy           high while a pass is in progress
//   done           one-cycle pulse when a pass completes
//   lines_cleared  rows removed by the last pass, held until the next start
//   grid_raddr     grid read address y*COLS+x
//   grid_rdata     cell value (0 = empty), valid one cycle after grid_raddr
//   grid_we        grid write strobe
//   grid_waddr     grid write address y*COLS+x
//   grid_wdata     grid write data
//   total_lines    (only with LINE_CLEAR_TOTAL_EN defined) saturating running
//                  sum of lines_cleared over all passes since reset
//
// Build option:
//   `define LINE_CLEAR_TOTAL_EN to add the total_lines accumulator output.
// -----------------------------------------------------------------------------
module line_clear_ctrl #(
  parameter int COLS = 10,
  parameter int ROWS = 12
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic [3:0] lines_cleared,
  output logic [6:0] grid_raddr,
  input  logic [1:0] grid_rdata,
  output logic       grid_we,
  output logic [6:0] grid_waddr,
  output logic [1:0] grid_wdata
`ifdef LINE_CLEAR_TOTAL_EN
  ,
  output logic [15:0] total_lines
`endif
);

  // Counter widths: x runs 0..COLS (one extra cycle drains the read pipe),
  // row counters run 0..ROWS-1.
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int XW = $clog2(COLS + 1);

  localparam logic [RW-1:0] R_LAST = RW'(ROWS - 1);
  localparam logic [RW-1:0] R_ZERO = '0;
  localparam logic [RW-1:0] R_ONE  = RW'(1);
  localparam logic [XW-1:0] X_ZERO = '0;
  localparam logic [XW-1:0] X_ONE  = XW'(1);
  localparam logic [XW-1:0] X_LAST = XW'(COLS - 1);
  localparam logic [XW-1:0] X_END  = XW'(COLS);
  localparam logic [3:0]    LC_MAX = 4'(ROWS);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SCAN  = 3'd1;
  localparam logic [2:0] ST_SHIFT = 3'd2;
  localparam logic [2:0] ST_CLEAR = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  logic [2:0]    state_reg, state_next;
  logic [RW-1:0] r_reg, r_next;        // row under test
  logic [RW-1:0] d_reg, d_next;        // destination row while shifting
  logic [XW-1:0] x_reg, x_next;        // cell index within the row
  logic          full_reg, full_next;  // running AND of nonzero flags
  logic [3:0]    lines_reg, lines_next;

  logic cell_nz;
  logic row_full;

  assign cell_nz  = (grid_rdata != 2'b00);
  // Final verdict for the row, folding in the last cell that arrives in the
  // drain cycle (x == COLS).
  assign row_full = full_reg & cell_nz;

  function automatic logic [6:0] cell_addr(input logic [RW-1:0] row,
                                           input logic [XW-1:0] col);
    return 7'(row) * 7'(COLS) + 7'(col);
  endfunction

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    r_next     = r_reg;
    d_next     = d_reg;
    x_next     = x_reg;
    full_next  = full_reg;
    lines_next = lines_reg;

    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          state_next = ST_SCAN;
          r_next     = R_LAST;
          x_next     = X_ZERO;
          full_next  = 1'b1;
          lines_next = 4'd0;
        end
      end

      ST_SCAN: begin
        if (x_reg == X_END) begin
          x_next    = X_ZERO;
          full_next = 1'b1;
          if (row_full) begin
            if (r_reg != R_ZERO) begin
              state_next = ST_SHIFT;
              d_next     = r_reg;
            end else begin
              // Top row full: nothing above it to move down.
              state_next = ST_CLEAR;
            end
          end else if (r_reg == R_ZERO) begin
            state_next = ST_DONE;
          end else begin
            r_next = r_reg - R_ONE;
          end
        end else begin
          x_next = x_reg + X_ONE;
          // Data seen at x=0 belongs to whatever was read before the row.
          if (x_reg != X_ZERO) begin
            full_next = full_reg & cell_nz;
          end
        end
      end

      ST_SHIFT: begin
        if (x_reg == X_END) begin
          x_next = X_ZERO;
          if (d_reg == R_ONE) begin
            state_next = ST_CLEAR;
          end else begin
            d_next = d_reg - R_ONE;
          end
        end else begin
          x_next = x_reg + X_ONE;
        end
      end

      ST_CLEAR: begin
        if (x_reg == X_LAST) begin
          x_next     = X_ZERO;
          full_next  = 1'b1;
          // r is left alone so the row that just moved down is rechecked.
          state_next = ST_SCAN;
          lines_next = (lines_reg == LC_MAX) ? lines_reg : lines_reg + 4'd1;
        end else begin
          x_next = x_reg + X_ONE;
        end
      end

      ST_DONE: begin
        state_next = ST_IDLE;
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= ST_IDLE;
      r_reg     <= '0;
      d_reg     <= '0;
      x_reg     <= '0;
      full_reg  <= 1'b0;
      lines_reg <= 4'd0;
    end else begin
      state_reg <= state_next;
      r_reg     <= r_next;
      d_reg     <= d_next;
      x_reg     <= x_next;
      full_reg  <= full_next;
      lines_reg <= lines_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: decoded from registered state, so an asserted reset drops every
  // strobe and address to zero without waiting for a clock edge.
  // ---------------------------------------------------------------------------
  always_comb begin
    grid_raddr = 7'd0;
    grid_we    = 1'b0;
    grid_waddr = 7'd0;
    grid_wdata = 2'b00;

    case (state_reg)
      ST_SCAN: begin
        // The drain cycle issues no read so the address never passes the
        // last cell of the grid.
        if (x_reg != X_END) begin
          grid_raddr = cell_addr(r_reg, x_reg);
        end
      end

      ST_SHIFT: begin
        if (x_reg != X_END) begin
          grid_raddr = cell_addr(d_reg - R_ONE, x_reg);
        end
        // Write lags the read by one cycle: cell x-1 of the source row is on
        // grid_rdata now.
        if (x_reg != X_ZERO) begin
          grid_we    = 1'b1;
          grid_waddr = cell_addr(d_reg, x_reg - X_ONE);
          grid_wdata = grid_rdata;
        end
      end

      ST_CLEAR: begin
        grid_we    = 1'b1;
        grid_waddr = cell_addr(R_ZERO, x_reg);
        grid_wdata = 2'b00;
      end

      default: begin
      end
    endcase
  end

  assign busy          = (state_reg == ST_SCAN) || (state_reg == ST_SHIFT) ||
                         (state_reg == ST_CLEAR);
  assign done          = (state_reg == ST_DONE);
  assign lines_cleared = lines_reg;

`ifdef LINE_CLEAR_TOTAL_EN
  // ---------------------------------------------------------------------------
  // Lifetime line counter, updated once per pass while done is high.
  // ---------------------------------------------------------------------------
  logic [15:0] total_reg;
  logic [16:0] total_sum;

  assign total_sum = {1'b0, total_reg} + {13'd0, lines_reg};

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      total_reg <= 16'd0;
    end else if (state_reg == ST_DONE) begin
      total_reg <= total_sum[16] ? 16'hFFFF : total_sum[15:0];
    end
  end

  assign total_lines = total_reg;
`endif

endmodule
